// File: rtl/game_timer_if.sv
// game_timer control/status bundle.
// master: game FSM side, slave: timer side.
interface game_timer_if #(
    parameter int SEC_W = 10
);
    logic             load;
    logic [SEC_W-1:0] sec_load;
    logic             mode_up;
    logic             start;
    logic             pause;
    logic             halt;
    logic [SEC_W-1:0] seconds_out;
    logic             running;
    logic             tick;
    logic             warning;
    logic             time_elapsed;

    modport master (
        output load, sec_load, mode_up,
        output start, pause, halt,
        input  seconds_out, running, tick,
        input  warning, time_elapsed
    );

    modport slave (
        input  load, sec_load, mode_up,
        input  start, pause, halt,
        output seconds_out, running, tick,
        output warning, time_elapsed
    );
endinterface

// File: rtl/game_timer.sv
// Second-resolution up/down game timer with pause/halt and warning.
// Define GAME_TIMER_BCD_EN to add the registered bcd_out port.
module game_timer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SEC_W    = 10,
    parameter int WARN_SEC = 10
) (
    input logic         clk,
    input logic         rst,
    game_timer_if.slave bus
`ifdef GAME_TIMER_BCD_EN
    ,
    output logic [4*((SEC_W*30103+99999)/100000)-1:0] bcd_out
`endif
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_HALT,
        S_EXP
    } state_t;

    state_t           state_q, state_n;
    logic [SEC_W-1:0] sec_q, sec_n;
    logic [SEC_W-1:0] lim_q, lim_n;
    logic             dir_q, dir_n;
    logic [PW-1:0]    pre_q, pre_n;
    logic             tick_q, tick_n;
    logic             run_q, run_n;
    logic             warn_q, warn_n;
    logic             exp_q, exp_n;

    logic [SEC_W-1:0] sec_step;
    logic             at_final;
    logic             step_final;

    // Final value test for the current value and the next step.
    always_comb begin
        sec_step   = dir_q ? sec_q + SEC_W'(1) : sec_q - SEC_W'(1);
        at_final   = dir_q ? (sec_q == lim_q) : (sec_q == '0);
        step_final = dir_q ? (sec_step == lim_q) : (sec_step == '0);
    end

    // Next state and next register values, load first.
    always_comb begin
        state_n = state_q;
        sec_n   = sec_q;
        lim_n   = lim_q;
        dir_n   = dir_q;
        pre_n   = pre_q;
        tick_n  = 1'b0;
        if (bus.load) begin
            dir_n   = bus.mode_up;
            sec_n   = bus.mode_up ? '0 : bus.sec_load;
            lim_n   = bus.mode_up ? bus.sec_load : lim_q;
            pre_n   = '0;
            state_n = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !at_final)
                        state_n = S_RUN;
                end
                S_RUN: begin
                    if (bus.halt) begin
                        state_n = S_HALT;
                    end else if (bus.pause) begin
                        state_n = S_PAUSE;
                    end else if (pre_q == P_LAST) begin
                        pre_n  = '0;
                        sec_n  = sec_step;
                        tick_n = 1'b1;
                        if (step_final)
                            state_n = S_EXP;
                    end else begin
                        pre_n = pre_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.halt)
                        state_n = S_HALT;
                    else if (!bus.pause)
                        state_n = S_RUN;
                end
                S_HALT, S_EXP: begin
                    state_n = state_q;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Status flags derived from the state being entered.
    always_comb begin
        run_n  = (state_n == S_RUN);
        exp_n  = (state_n == S_EXP);
        warn_n = !dir_n
              && (state_n == S_RUN || state_n == S_PAUSE)
              && (sec_n != '0)
              && (32'(sec_n) <= 32'(WARN_SEC));
    end

    // Timer registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            warn_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            sec_q   <= sec_n;
            lim_q   <= lim_n;
            dir_q   <= dir_n;
            pre_q   <= pre_n;
            tick_q  <= tick_n;
            run_q   <= run_n;
            warn_q  <= warn_n;
            exp_q   <= exp_n;
        end
    end

    assign bus.seconds_out  = sec_q;
    assign bus.running      = run_q;
    assign bus.tick         = tick_q;
    assign bus.warning      = warn_q;
    assign bus.time_elapsed = exp_q;

`ifdef GAME_TIMER_BCD_EN
    localparam int BCD_W = 4 * ((SEC_W * 30103 + 99999) / 100000);

    // Double-dabble binary to packed BCD.
    function automatic logic [BCD_W-1:0] to_bcd(
        input logic [SEC_W-1:0] bin
    );
        logic [BCD_W-1:0] acc;
        acc = '0;
        for (int i = SEC_W - 1; i >= 0; i--) begin
            for (int d = 0; d < BCD_W / 4; d++) begin
                if (acc[4*d +: 4] >= 4'd5)
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
            acc = {acc[BCD_W-2:0], bin[i]};
        end
        return acc;
    endfunction

    logic [BCD_W-1:0] bcd_q;

    // BCD tracks the value written into seconds_out.
    always_ff @(posedge clk) begin
        if (rst)
            bcd_q <= '0;
        else
            bcd_q <= to_bcd(sec_n);
    end

    assign bcd_out = bcd_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed table-driven bench for game_timer.
// CLK_HZ=4, SEC_W=10, WARN_SEC=10.
module tb_game_timer;

    logic clk;
    logic rst;

    game_timer_if #(.SEC_W(10)) bus ();

`ifdef GAME_TIMER_BCD_EN
    logic [15:0] bcd_out;
`endif

    game_timer #(
        .CLK_HZ  (4),
        .SEC_W   (10),
        .WARN_SEC(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus)
`ifdef GAME_TIMER_BCD_EN
        ,
        .bcd_out(bcd_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [9:0] sl;
        logic       mu;
        logic       st;
        logic       pa;
        logic       ha;
        logic       rs;
        logic [9:0] sec;
        logic       run;
        logic       tk;
        logic       wr;
        logic       el;
        int         scen;
    } vec_t;

    vec_t tbl[$];
    int   scen;
    int   checks;
    int   errors;

    task automatic row(
        input logic       ld,
        input logic [9:0] sl,
        input logic       mu, st, pa, ha, rs,
        input logic [9:0] sec,
        input logic       run, tk, wr, el
    );
        vec_t v;
        v.ld = ld; v.sl = sl; v.mu = mu;
        v.st = st; v.pa = pa; v.ha = ha;
        v.rs = rs; v.sec = sec; v.run = run;
        v.tk = tk; v.wr = wr; v.el = el;
        v.scen = scen;
        tbl.push_back(v);
    endtask

    function automatic logic wv(input int s);
        return (s != 0) && (s <= 10);
    endfunction

    // idle-input row expecting given outputs
    task automatic idle(
        input int s, input logic run, tk, wr, el
    );
        row(0, 0, 0, 0, 0, 0, 0, 10'(s), run, tk, wr, el);
    endtask

    // load n down, start, count to 0
    task automatic add_down(input int n);
        row(1, 10'(n), 0, 0, 0, 0, 0,
            10'(n), 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0,
            10'(n), 1, 0, wv(n), 0);
        for (int s = n - 1; s >= 0; s--) begin
            for (int k = 0; k < 3; k++)
                idle(s + 1, 1, 0, wv(s + 1), 0);
            idle(s, s != 0, 1, wv(s), s == 0);
        end
    endtask

    // load n up, start, count to n
    task automatic add_up(input int n);
        row(1, 10'(n), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int s = 1; s <= n; s++) begin
            for (int k = 0; k < 3; k++)
                idle(s - 1, 1, 0, 0, 0);
            idle(s, s != n, 1, 0, s == n);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [13:0] got, exp;
        rst          = v.rs;
        bus.load     = v.ld;
        bus.sec_load = v.sl;
        bus.mode_up  = v.mu;
        bus.start    = v.st;
        bus.pause    = v.pa;
        bus.halt     = v.ha;
        @(posedge clk);
        #1;
        got = {bus.seconds_out, bus.running, bus.tick,
               bus.warning, bus.time_elapsed};
        exp = {v.sec, v.run, v.tk, v.wr, v.el};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row%0d scen%0d {sec,run,tick,warn,el} got %0d,%b%b%b%b want %0d,%b%b%b%b",
                     idx, v.scen,
                     got[13:4], got[3], got[2], got[1], got[0],
                     exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.sec_load = '0;
        bus.mode_up  = 1'b0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.halt     = 1'b0;

        // 0: reset values
        scen = 0;
        row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // 1: down from 3, then start ignored in EXPIRED
        scen = 1;
        add_down(3);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // 2: up to 5, then start ignored
        scen = 2;
        add_up(5);
        row(0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1);

        // 3: down from 12, warning window 10..1
        scen = 3;
        add_down(12);

        // 4: load 0 down, start refused
        scen = 4;
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);

        // 5: pause on 6 edges -> 7 frozen edges
        scen = 5;
        row(1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 1, 0);
        idle(2, 1, 0, 1, 0);
        idle(2, 1, 0, 1, 0);
        for (int k = 0; k < 6; k++)
            row(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
        idle(2, 1, 0, 1, 0);
        idle(2, 1, 0, 1, 0);
        idle(1, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++)
            idle(1, 1, 0, 1, 0);
        idle(0, 0, 1, 0, 1);

        // 6: halt at prescaler end, then reload
        scen = 6;
        row(1, 5, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++)
            idle(5, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            idle(5, 0, 0, 0, 0);
        row(1, 9, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 9, 1, 0, 1, 0);

        // 7: reset mid-run clears everything
        scen = 7;
        idle(9, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i])
            apply(tbl[i], i);

`ifdef GAME_TIMER_BCD_EN
        // BCD of 999 and of its first down step
        rst = 1'b0;
        bus.load = 1'b1;
        bus.sec_load = 10'd999;
        bus.mode_up = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.halt = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bcd_out !== 16'h0999) begin
            errors++;
            $display("FAIL bcd_load got %h want 0999", bcd_out);
        end
        bus.load = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bcd_out !== 16'h0998 || bus.tick !== 1'b1) begin
            errors++;
            $display("FAIL bcd_step got %h tick %b want 0998 1",
                     bcd_out, bus.tick);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
